// File: rtl/parity_frame_sched_pkg.sv
// Shared types and constants for the parity frame scheduler.
package parity_sched_pkg;

    localparam int FRAME_BITS_DEF = 8;
    localparam int ID_W           = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/parity_frame_sched_if.sv
// Requester, checker and result signals of the parity frame scheduler.
interface parity_frame_sched_if
    import parity_sched_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF
);
    logic                  req0_valid;
    logic                  req1_valid;
    logic [FRAME_BITS-1:0] req0_data;
    logic [FRAME_BITS-1:0] req1_data;
    logic                  req0_mode;
    logic                  req1_mode;
    logic                  req0_ready;
    logic                  req1_ready;
    logic                  chk_reset;
    logic                  chk_valid;
    logic                  chk_data_in;
    logic                  chk_mode;
    logic                  chk_parity_ok;
    logic [3:0]            chk_counter;
    logic                  res_valid;
    logic                  res_id;
    logic                  res_ok;
    logic [7:0]            err_cnt0;
    logic [7:0]            err_cnt1;

    modport master (
        output req0_valid, req1_valid, req0_data, req1_data, req0_mode, req1_mode,
        output chk_parity_ok, chk_counter,
        input  req0_ready, req1_ready, chk_reset, chk_valid, chk_data_in, chk_mode,
        input  res_valid, res_id, res_ok, err_cnt0, err_cnt1
    );

    modport slave (
        input  req0_valid, req1_valid, req0_data, req1_data, req0_mode, req1_mode,
        input  chk_parity_ok, chk_counter,
        output req0_ready, req1_ready, chk_reset, chk_valid, chk_data_in, chk_mode,
        output res_valid, res_id, res_ok, err_cnt0, err_cnt1
    );

endinterface

// File: rtl/parity_frame_sched_rr_arb2.sv
// Two-way round-robin arbiter; after reset requester 0 has priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last;

    always_comb begin
        grant = req;
        if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
    end

    // last=1 means requester 1 was granted most recently
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  last <= 1'b1;
        else if (accept && |grant)  last <= grant[1];
    end

endmodule

// File: rtl/parity_frame_sched.sv
// Serializes frames from two requesters into a parity checker and reports results.
// Optional per-requester failure counters: define PARITY_SCHED_STATS_EN.
module parity_frame_sched
    import parity_sched_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input logic                 clk,
    input logic                 reset,
    parity_frame_sched_if.slave bus
);
    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_CLR   = ST_CLR;
    localparam logic [2:0] S_SHIFT = ST_SHIFT;
    localparam logic [2:0] S_WAIT  = ST_WAIT;
    localparam logic [2:0] S_DONE  = ST_DONE;

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [3:0] CNT_EXP  = 4'(FRAME_BITS % 16);

    logic [2:0]            state;
    logic [3:0]            bit_idx;
    logic                  ok_lat;
    logic [FRAME_BITS-1:0] shreg;
    logic                  mode_lat;
    logic [ID_W-1:0]       id_lat;
    logic [1:0]            grant;
    logic                  idle;

    // Reset is folded in so ready stays low while reset is held
    assign idle = (state == S_IDLE) && !reset;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    ({bus.req1_valid, bus.req0_valid}),
        .accept (idle),
        .grant  (grant)
    );

    assign bus.req0_ready = idle & grant[0];
    assign bus.req1_ready = idle & grant[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_idx <= '0;
            ok_lat  <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (|grant) state <= S_CLR;
                S_CLR: begin
                    bit_idx <= '0;
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bit_idx == LAST_BIT) state <= S_WAIT;
                    else                     bit_idx <= bit_idx + 4'd1;
                end
                S_WAIT: begin
                    ok_lat <= bus.chk_parity_ok && (bus.chk_counter == CNT_EXP);
                    state  <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Payload path: no reset needed, every output it feeds is gated by state
    always_ff @(posedge clk) begin
        if (state == S_IDLE && |grant) begin
            shreg    <= grant[1] ? bus.req1_data : bus.req0_data;
            mode_lat <= grant[1] ? bus.req1_mode : bus.req0_mode;
            id_lat   <= grant[1];
        end else if (state == S_SHIFT) begin
            shreg <= shreg >> 1;
        end
    end

    assign bus.chk_reset   = (state == S_CLR);
    assign bus.chk_valid   = (state == S_SHIFT);
    assign bus.chk_data_in = bus.chk_valid & shreg[0];
    assign bus.chk_mode    = bus.chk_valid & mode_lat;
    assign bus.res_valid   = (state == S_DONE);
    assign bus.res_id      = bus.res_valid & id_lat[0];
    assign bus.res_ok      = bus.res_valid & ok_lat;

`ifdef PARITY_SCHED_STATS_EN
    logic [7:0] err0;
    logic [7:0] err1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err0 <= '0;
            err1 <= '0;
        end else if (state == S_DONE && !ok_lat) begin
            if (id_lat[0]) err1 <= sat_inc(err1);
            else           err0 <= sat_inc(err0);
        end
    end

    assign bus.err_cnt0 = err0;
    assign bus.err_cnt1 = err1;
`else
    assign bus.err_cnt0 = '0;
    assign bus.err_cnt1 = '0;
`endif

endmodule

// File: tb/tb_parity_frame_sched.sv
// Randomized self-checking bench for parity_frame_sched with a frame-level reference model.
module tb_parity_frame_sched;
    import parity_sched_pkg::*;

    localparam int FB = 8;
`ifdef PARITY_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    parity_frame_sched_if #(.FRAME_BITS(FB)) bus ();
    parity_frame_sched #(.FRAME_BITS(FB)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int model_last;      // requester granted most recently (1 after reset => req0 wins)
    int model_err[2];

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [24:0] out_vec();
        return {bus.req0_ready, bus.req1_ready, bus.chk_reset, bus.chk_valid, bus.chk_data_in,
                bus.chk_mode, bus.res_valid, bus.res_id, bus.res_ok, bus.err_cnt0, bus.err_cnt1};
    endfunction

    function automatic int sat_exp(input int n);
        if (!STATS) return 0;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic drive_idle;
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_data = '0; bus.req1_data = '0;
        bus.req0_mode = 0; bus.req1_mode = 0;
        bus.chk_parity_ok = 0; bus.chk_counter = '0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        drive_idle();
        tick();
        tick();
        reset = 1'b0;
        model_last = 1;
        model_err[0] = 0;
        model_err[1] = 0;
    endtask

    // One complete frame: waits for a grant, then checks every cycle through DONE.
    task automatic run_frame(input logic v0, input logic v1, input logic [FB-1:0] d0,
                             input logic [FB-1:0] d1, input logic m0, input logic m1,
                             input logic ok, input logic [3:0] cnt, input string tag,
                             output int gid_obs, output int gap);
        int gid;
        logic [FB-1:0] gd;
        logic gm, exp_ok, in_shift, exp_din;
        logic [6:0] exp_v, obs_v;
        bus.req0_valid = v0; bus.req1_valid = v1;
        bus.req0_data = d0;  bus.req1_data = d1;
        bus.req0_mode = m0;  bus.req1_mode = m1;
        // decoy checker values give the opposite verdict unless sampled at the WAIT edge
        bus.chk_parity_ok = ~ok;
        bus.chk_counter = 4'(FB % 16);
        gap = 0;
        gid_obs = -1;
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && gap < 30) begin
            tick();
            gap++;
        end
        checks++;
        if (gap >= 30) begin
            $display("FAIL %s no_grant ready=%b%b required=grant within 30 cycles",
                     tag, bus.req1_ready, bus.req0_ready);
            errors++;
            return;
        end
        gid = (v0 && v1) ? ((model_last == 0) ? 1 : 0) : (v1 ? 1 : 0);
        gid_obs = bus.req1_ready ? 1 : 0;
        if ({bus.req1_ready, bus.req0_ready} !== ((gid == 1) ? 2'b10 : 2'b01)) begin
            $display("FAIL %s grant ready1/0=%b%b required=%0d", tag,
                     bus.req1_ready, bus.req0_ready, gid);
            errors++;
        end
        model_last = gid;
        gd = (gid == 1) ? d1 : d0;
        gm = (gid == 1) ? m1 : m0;
        exp_ok = ok && (cnt == 4'(FB % 16));
        for (int c = 1; c <= FB + 3; c++) begin
            tick();
            if (c == FB + 2) begin
                bus.chk_parity_ok = ok;
                bus.chk_counter = cnt;
            end
            in_shift = (c >= 2) && (c <= FB + 1);
            exp_din = 1'b0;
            if (in_shift) exp_din = gd[c-2];
            exp_v = {1'b0, 1'b0, (c == 1), in_shift, exp_din, in_shift & gm, (c == FB + 3)};
            obs_v = {bus.req0_ready, bus.req1_ready, bus.chk_reset, bus.chk_valid,
                     bus.chk_data_in, bus.chk_mode, bus.res_valid};
            checks++;
            if (obs_v !== exp_v) begin
                $display("FAIL %s cycle%0d rdy0,rdy1,clr,vld,din,mode,res=%b required=%b",
                         tag, c, obs_v, exp_v);
                errors++;
            end
            if (c == FB + 3) begin
                checks++;
                if ({bus.res_id, bus.res_ok} !== {1'(gid), exp_ok}) begin
                    $display("FAIL %s result id,ok=%b required=%b", tag,
                             {bus.res_id, bus.res_ok}, {1'(gid), exp_ok});
                    errors++;
                end
            end
        end
        if (!exp_ok) model_err[gid]++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive_idle();
        bus.req0_valid = 1; bus.req1_valid = 1;
        tick();
        checks++;
        if (out_vec() !== '0) begin
            $display("FAIL reset_hold outputs=%h required=0", out_vec());
            errors++;
        end
        drive_idle();
        reset = 1'b0;
        model_last = 1;
        model_err[0] = 0;
        model_err[1] = 0;
        #1;
        checks++;
        if (out_vec() !== '0) begin
            $display("FAIL reset_release outputs=%h required=0", out_vec());
            errors++;
        end
    endtask

    task automatic test_single;
        int g, gap;
        apply_reset();
        run_frame(1, 0, 8'h0D, 8'h00, 1, 0, 1, 4'd8, "single", g, gap);
        drive_idle();
    endtask

    task automatic test_mismatch;
        int g, gap;
        run_frame(1, 0, 8'hA5, 8'h00, 0, 0, 1, 4'd7, "mismatch", g, gap);
        run_frame(0, 1, 8'h00, 8'h3C, 1, 1, 0, 4'd8, "not_ok", g, gap);
        drive_idle();
    endtask

    task automatic test_contention;
        int g, gap;
        int exp_seq[4] = '{0, 1, 0, 1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_frame(1, 1, FB'($urandom), FB'($urandom), 1'($urandom), 1'($urandom),
                      1, 4'(FB % 16), "contention", g, gap);
            checks++;
            if (g !== exp_seq[i]) begin
                $display("FAIL contention_order frame%0d granted=%0d required=%0d", i, g, exp_seq[i]);
                errors++;
            end
            if (i > 0) begin
                checks++;
                if (gap !== 1) begin
                    $display("FAIL contention_regrant frame%0d idle_gap=%0d required=1", i, gap);
                    errors++;
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_random;
        int g, gap, v;
        logic [3:0] cnt;
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(1, 3);
            cnt = ($urandom_range(0, 1) == 1) ? 4'(FB % 16) : 4'($urandom_range(0, 15));
            run_frame(1'(v), 1'(v >> 1), FB'($urandom), FB'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), cnt, "random", g, gap);
        end
        drive_idle();
    endtask

    task automatic test_mid_reset;
        int g, gap;
        run_frame(0, 1, 8'h00, 8'h55, 0, 1, 1, 4'(FB % 16), "pre_reset", g, gap);
        bus.req0_valid = 1; bus.req1_valid = 1;
        bus.req0_data = 8'hF0; bus.req1_data = 8'h0F;
        #1;
        gap = 0;
        while (!(bus.req0_ready || bus.req1_ready) && gap < 30) begin
            tick();
            gap++;
        end
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            $display("FAIL midreset_grant ready1/0=%b%b required=01", bus.req1_ready, bus.req0_ready);
            errors++;
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.chk_valid !== 1'b1) begin
            $display("FAIL midreset_in_shift chk_valid=%b required=1", bus.chk_valid);
            errors++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_vec() !== '0) begin
            $display("FAIL midreset_outputs outputs=%h required=0", out_vec());
            errors++;
        end
        tick();
        checks++;
        if (out_vec() !== '0) begin
            $display("FAIL midreset_held outputs=%h required=0", out_vec());
            errors++;
        end
        reset = 1'b0;
        model_last = 1;
        model_err[0] = 0;
        model_err[1] = 0;
        run_frame(1, 1, 8'hC3, 8'h81, 1, 0, 1, 4'(FB % 16), "post_reset", g, gap);
        checks++;
        if (g !== 0 || gap !== 0) begin
            $display("FAIL post_reset_priority granted=%0d gap=%0d required=0 gap=0", g, gap);
            errors++;
        end
        drive_idle();
    endtask

    task automatic test_stats;
        int g, gap;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            run_frame(0, 1, 8'h00, FB'($urandom), 1'b0, 1'($urandom), 1'b0, 4'(FB % 16),
                      "stats", g, gap);
            tick();
            checks++;
            if ({bus.err_cnt0, bus.err_cnt1} !== {8'(sat_exp(model_err[0])), 8'(sat_exp(model_err[1]))}) begin
                $display("FAIL stats_count frame%0d err0=%0d err1=%0d required %0d %0d", i,
                         bus.err_cnt0, bus.err_cnt1, sat_exp(model_err[0]), sat_exp(model_err[1]));
                errors++;
            end
        end
        drive_idle();
        reset = 1'b1;
        #1;
        checks++;
        if (out_vec() !== '0) begin
            $display("FAIL stats_reset outputs=%h required=0", out_vec());
            errors++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_single();
        test_mismatch();
        test_contention();
        test_random();
        test_mid_reset();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/parity_frame_sched.md
PARITY_FRAME_SCHED -- requirements
Module: parity_frame_sched

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 8, giving the number of bits serialized per frame (range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each, requester has a frame pending.
REQ-005 The block SHALL have ports req0_data/req1_data, input, FRAME_BITS each, frame payload, held stable while valid.
REQ-006 The block SHALL have ports req0_mode/req1_mode, input, 1 each, parity mode forwarded to the checker.
REQ-007 The block SHALL have ports req0_ready/req1_ready, output, 1 each, one-cycle accept pulse.
REQ-008 The block SHALL have ports chk_reset, chk_valid, chk_data_in, chk_mode, output, 1 each, driving the parity checker.
REQ-009 The block SHALL have ports chk_parity_ok, input, 1, and chk_counter, input, 4, from the checker.
REQ-010 The block SHALL have ports res_valid, output, 1; res_id, output, 1; res_ok, output, 1, the per-frame result.
REQ-011 The block SHALL have ports err_cnt0/err_cnt1, output, 8 each, per-requester parity-failure counts.

Function
REQ-012 The FSM SHALL have states IDLE, CLR, SHIFT, WAIT, DONE.
REQ-013 In IDLE with any reqN_valid, the block SHALL grant one requester, pulse its reqN_ready for that cycle, latch data, mode and id, and go to CLR.
REQ-014 Arbitration SHALL be round-robin: if both are valid, grant the requester not granted last; after reset req0 wins.
REQ-015 CLR SHALL last 1 cycle with chk_reset=1 and chk_valid=0.
REQ-016 SHIFT SHALL last exactly FRAME_BITS cycles with chk_valid=1, LSB first on chk_data_in, and the latched mode on chk_mode.
REQ-017 WAIT SHALL last 1 cycle with chk_valid=0; the block SHALL sample chk_parity_ok at its end.
REQ-018 A result is consistent only if chk_counter equals FRAME_BITS mod 16 at that sample; otherwise res_ok SHALL be forced to 0.
REQ-019 DONE SHALL last 1 cycle with res_valid=1, res_id=granted requester, res_ok=sampled result, then return to IDLE.
REQ-020 Latency SHALL be FRAME_BITS+3 cycles from the ready edge to the res_valid cycle; a new grant is possible in the following IDLE cycle.
REQ-021 Requests arriving outside IDLE SHALL wait; ready is never asserted outside IDLE.
REQ-022 Outside SHIFT, chk_data_in and chk_mode SHALL be 0.

Reset
REQ-023 On reset the FSM SHALL go to IDLE immediately, including mid-frame, and the in-flight frame SHALL be dropped without a result.
REQ-024 Reset SHALL drive all outputs to 0, including the err_cnt values, and restore req0 priority.

Configuration
REQ-025 With macro PARITY_SCHED_STATS_EN defined, err_cntN SHALL increment in DONE when res_ok=0 for requester N, saturating at 255.
REQ-026 Without PARITY_SCHED_STATS_EN, err_cnt0/err_cnt1 SHALL be constant 0 and no counter registers SHALL exist.

Structure
REQ-027 A package parity_sched_pkg SHALL hold the FSM state enum, the default FRAME_BITS constant and the requester-id width.
REQ-028 A sub-module rr_arb2 SHALL implement the 2-way round-robin arbiter (req[1:0], grant[1:0], last-grant register).

Verification
REQ-029 Single request: req0 data=8'h0D, mode=1, stub checker returns ok=1, counter=8 -> ready pulse at T; SHIFT bits 1,0,1,1,0,0,0,0; res_valid at T+11 with id=0, ok=1.
REQ-030 Contention: req0 and req1 both valid from reset -> req0 granted first, req1 in the next IDLE; both held continuously -> grants alternate 0,1,0,1.
REQ-031 Counter mismatch: stub counter=7 with ok=1 at the WAIT sample -> res_ok=0.
REQ-032 Mid-frame reset: assert reset in the 4th SHIFT cycle -> outputs 0 at once, no res_valid, next grant goes to req0.
REQ-033 Stats (PARITY_SCHED_STATS_EN): 300 failing frames on req1 -> err_cnt1=255 and err_cnt0=0; without the macro -> both 0.
